alu_pipe_muldiv: RTL and testbench
==================================

Name: alu_pipe_muldiv

Overview:
Registered, parametrised successor to the combinational MIPS ALU.
- Executes the same 19 R/I-type operations with one-cycle registered latency.
- Adds iterative unsigned multiply/divide (MULTU, DIVU) writing internal HI/LO registers, plus MFHI/MFLO reads.
- Sits between ID/EX operand latches and the EX/MEM register and uses a valid/ready handshake, so the pipeline can stall while the block is busy.

Parameters:
- SIZEDATA, 8: operand/result width in bits; must be ≥ 4 and even.
- SIZEOP, 6: opcode/funct width.
- SHAMT_W, $clog2(SIZEDATA): number of low bits of i_datob used as shift amount.

Ports:
- i_clock  in  1  system clock; all state updates on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  operands and opcode valid this cycle.
- o_ready  out  1  block can accept; a transfer occurs when i_valid && o_ready at a rising edge.
- i_datoa  in  SIZEDATA  operand A (rs); also the value shifted.
- i_datob  in  SIZEDATA  operand B (rt/immediate); low SHAMT_W bits are the shift amount.
- i_opcode  in  SIZEOP  operation select.
- o_result  out  SIZEDATA  registered result; holds until the next completion.
- o_valid  out  1  one-cycle pulse marking a new o_result.
- o_div_zero  out  1  pulse with o_valid when DIVU divisor == 0.
- o_illegal  out  1  pulse with o_valid for an unrecognised opcode.

Behaviour:
- Reset (i_reset high at an edge): o_result=0, o_valid=0, o_div_zero=0, o_illegal=0, o_ready=1, HI=LO=0, FSM→IDLE. Reset aborts any in-flight MULTU/DIVU; no o_valid is produced for the aborted operation.
- Opcodes:
  - SLL 000000, SRL 000010, SRA 000011, SLLV 000100, SRLV 000110, SRAV 000111, ADDU 100001, SUBU 100011, AND 100100, OR 100101, XOR 100110, NOR 100111, SLT 101010.
  - ADDI 001000, SLTI 001010, ANDI 001100, ORI 001101, XORI 001110, LUI 001111.
  - New: MFHI 010000, MFLO 010010, MULTU 011001, DIVU 011011.
- Semantics:
  - All shifts shift A by B[SHAMT_W-1:0]. SRA/SRAV are arithmetic.
  - Add and subtract wrap modulo 2^SIZEDATA; no overflow flag.
  - SLT/SLTI are a signed compare and return the zero-extended value 1 or 0.
  - LUI = B << (SIZEDATA/2).
  - Any other opcode: result 0 and o_illegal=1.
- FSM states: IDLE, MUL, DIV.
  - IDLE: o_ready=1. On accept of a single-cycle op, o_result/o_valid register at that edge, so o_valid is high in the following cycle. Latency is 1 and throughput is 1 per cycle.
  - IDLE→MUL on accepting MULTU. Shift-add runs one bit per cycle for SIZEDATA cycles, with o_ready=0. At completion {HI,LO}=A*B (2*SIZEDATA bits), o_result=LO, o_valid pulse, →IDLE. o_valid rises SIZEDATA+1 cycles after the accept edge.
  - IDLE→DIV on accepting DIVU with B≠0. Restoring division runs SIZEDATA cycles, then LO=quotient, HI=remainder, o_result=LO, o_valid, →IDLE. Latency is SIZEDATA+1.
  - DIVU with B==0: no DIV state. Completes with latency 1: LO=all ones, HI=A, o_result=LO, o_div_zero=1.
- While in MUL or DIV: i_valid is ignored, because o_ready=0. Operands are captured at accept, so later input changes have no effect.
- MFHI/MFLO: single-cycle ops returning the current HI/LO. Issued back-to-back after MULTU completes, they see the new values.
- HI/LO change only on MULTU/DIVU completion or on reset.
- o_valid, o_div_zero and o_illegal are each high for exactly one cycle per completion.

Decomposition:
- Shared package alu_pkg: opcode localparams, FSM state encoding, and a SIZEDATA-generic shift-amount width function.
- One sub-module, alu_muldiv_iter, holds the iterative engine.
  - Interface: start, mode (mul/div), a, b, busy, done, hi, lo.
  - Internals: counter, partial product, remainder.
- The top level holds the combinational op decode, the FSM/handshake and the HI/LO registers.

Test Plan (SIZEDATA=8):
1. ADDU A=8'h7F, B=8'h01 accepted at edge k → o_result=8'h80, o_valid high only in cycle k+1. SUBU 8'h00-8'h01 → 8'hFF.
2. SRA A=8'b1000_0000, B=3 → 8'b1111_0000. SRL same operands → 8'b0001_0000. SLT A=-8, B=3 → 1. LUI B=8'h0A → 8'hA0.
3. MULTU A=200, B=100 → o_ready=0 for 8 cycles, then o_valid at k+9 with o_result=8'h20. Next MFHI → 8'h4E, MFLO → 8'h20.
4. DIVU A=100, B=7 → latency 9, LO=14, HI=2. Then DIVU A=5, B=0 → latency 1, o_result=8'hFF, o_div_zero=1, MFHI → 5.
5. Hold i_valid with ADDU during MULTU busy → no extra o_valid; the ADDU is accepted only on the cycle o_ready returns. Assert i_reset during cycle 4 of a DIVU → next cycle o_ready=1, o_valid=0, MFHI/MFLO → 0.
6. Opcode 6'b111111 → o_result=0, o_illegal and o_valid pulse together for one cycle; HI/LO unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined MIPS ALU with iterative multiply/divide.
// Contents: opcode encodings, FSM and engine-mode enums, and a shift-amount width helper.
package alu_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [5:0] OP_SLL   = 6'b000000;
  localparam logic [5:0] OP_SRL   = 6'b000010;
  localparam logic [5:0] OP_SRA   = 6'b000011;
  localparam logic [5:0] OP_SLLV  = 6'b000100;
  localparam logic [5:0] OP_SRLV  = 6'b000110;
  localparam logic [5:0] OP_SRAV  = 6'b000111;
  localparam logic [5:0] OP_ADDU  = 6'b100001;
  localparam logic [5:0] OP_SUBU  = 6'b100011;
  localparam logic [5:0] OP_AND   = 6'b100100;
  localparam logic [5:0] OP_OR    = 6'b100101;
  localparam logic [5:0] OP_XOR   = 6'b100110;
  localparam logic [5:0] OP_NOR   = 6'b100111;
  localparam logic [5:0] OP_SLT   = 6'b101010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_MFHI  = 6'b010000;
  localparam logic [5:0] OP_MFLO  = 6'b010010;
  localparam logic [5:0] OP_MULTU = 6'b011001;
  localparam logic [5:0] OP_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  typedef enum logic {
    MD_MUL = 1'b0,
    MD_DIV = 1'b1
  } md_mode_e;

  function automatic int shamt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply and restoring divide, one bit per cycle.
// The first step is applied at the start edge, so done is seen W cycles after start.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         i_clock,
  input  logic         i_reset,
  input  logic         i_start,
  input  md_mode_e     i_mode,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_hi,
  output logic [W-1:0] o_lo
);

  localparam int CNT_W = shamt_w(W);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  md_mode_e         mode_q, mode_d;

  // acc holds {partial product, multiplier} for MUL and {remainder, quotient} for DIV
  function automatic logic [2*W-1:0] step(input md_mode_e md, input logic [2*W-1:0] acc,
                                          input logic [W-1:0] opnd);
    logic [W:0]   sum;
    logic [W:0]   trial;
    logic [W-1:0] rem_n;
    sum   = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : {(W+1){1'b0}});
    trial = {acc[2*W-1:W], acc[W-1]};
    rem_n = trial[W-1:0] - opnd;
    if (md == MD_MUL) begin
      return {sum, acc[W-1:1]};
    end else if (trial >= {1'b0, opnd}) begin
      return {rem_n, acc[W-2:0], 1'b1};
    end else begin
      return {trial[W-1:0], acc[W-2:0], 1'b0};
    end
  endfunction

  // Next-state for the iteration counter and datapath
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    mode_d = mode_q;
    if (i_start) begin
      mode_d = i_mode;
      opnd_d = (i_mode == MD_MUL) ? i_a : i_b;
      acc_d  = step(i_mode, {{W{1'b0}}, (i_mode == MD_MUL) ? i_b : i_a}, opnd_d);
      cnt_d  = CNT_W'(W - 1);
      busy_d = 1'b1;
    end else if (busy_q && (cnt_q != {CNT_W{1'b0}})) begin
      acc_d = step(mode_q, acc_q, opnd_q);
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      busy_d = 1'b0;
    end
  end

  // Engine state registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      busy_q <= 1'b0;
      cnt_q  <= {CNT_W{1'b0}};
      acc_q  <= {(2*W){1'b0}};
      opnd_q <= {W{1'b0}};
      mode_q <= MD_MUL;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
      mode_q <= mode_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = busy_q && (cnt_q == {CNT_W{1'b0}});
  assign o_hi   = acc_q[2*W-1:W];
  assign o_lo   = acc_q[W-1:0];

endmodule

// File: rtl/alu_pipe_muldiv.sv
// Registered MIPS ALU with valid/ready handshake, HI/LO registers and iterative MULTU/DIVU.
// Single-cycle ops complete at the accept edge; MULTU/DIVU hold o_ready low while iterating.
module alu_pipe_muldiv
  import alu_pkg::*;
#(
  parameter int SIZEDATA = 8,
  parameter int SIZEOP   = 6,
  parameter int SHAMT_W  = shamt_w(SIZEDATA)
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZEDATA-1:0] i_datoa,
  input  logic [SIZEDATA-1:0] i_datob,
  input  logic [SIZEOP-1:0]   i_opcode,
  output logic [SIZEDATA-1:0] o_result,
  output logic                o_valid,
  output logic                o_div_zero,
  output logic                o_illegal
);

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic [SIZEDATA-1:0]   result_q, result_d;
  logic                  valid_q, valid_d;
  logic                  div_zero_q, div_zero_d;
  logic                  illegal_q, illegal_d;
  logic [SIZEDATA-1:0]   hi_q, hi_d;
  logic [SIZEDATA-1:0]   lo_q, lo_d;

  logic [OPCODE_W-1:0]   op_s;
  logic [SHAMT_W-1:0]    shamt_s;
  logic [SIZEDATA-1:0]   alu_res_s;
  logic                  alu_known_s;
  logic                  eng_start_s;
  md_mode_e              eng_mode_s;
  logic                  eng_busy_s;
  logic                  eng_done_s;
  logic [SIZEDATA-1:0]   eng_hi_s;
  logic [SIZEDATA-1:0]   eng_lo_s;

  assign op_s    = OPCODE_W'(i_opcode);
  assign shamt_s = i_datob[SHAMT_W-1:0];

  // Single-cycle operation decode; unknown opcodes yield zero and are flagged
  always_comb begin
    alu_res_s   = {SIZEDATA{1'b0}};
    alu_known_s = 1'b1;
    case (op_s)
      OP_SLL, OP_SLLV:   alu_res_s = i_datoa << shamt_s;
      OP_SRL, OP_SRLV:   alu_res_s = i_datoa >> shamt_s;
      OP_SRA, OP_SRAV:   alu_res_s = $signed(i_datoa) >>> shamt_s;
      OP_ADDU, OP_ADDI:  alu_res_s = i_datoa + i_datob;
      OP_SUBU:           alu_res_s = i_datoa - i_datob;
      OP_AND, OP_ANDI:   alu_res_s = i_datoa & i_datob;
      OP_OR, OP_ORI:     alu_res_s = i_datoa | i_datob;
      OP_XOR, OP_XORI:   alu_res_s = i_datoa ^ i_datob;
      OP_NOR:            alu_res_s = ~(i_datoa | i_datob);
      OP_SLT, OP_SLTI:   alu_res_s = {{(SIZEDATA-1){1'b0}}, ($signed(i_datoa) < $signed(i_datob))};
      OP_LUI:            alu_res_s = i_datob << (SIZEDATA / 2);
      OP_MFHI:           alu_res_s = hi_q;
      OP_MFLO:           alu_res_s = lo_q;
      OP_MULTU, OP_DIVU: alu_res_s = {SIZEDATA{1'b0}};
      default:           alu_known_s = 1'b0;
    endcase
  end

  // Handshake FSM, result and HI/LO next-state
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    div_zero_d  = 1'b0;
    illegal_d   = 1'b0;
    hi_d        = hi_q;
    lo_d        = lo_q;
    eng_start_s = 1'b0;
    eng_mode_s  = MD_MUL;
    case (state_q)
      ST_IDLE: begin
        if (i_valid && ready_q) begin
          if (op_s == OP_MULTU) begin
            eng_start_s = 1'b1;
            eng_mode_s  = MD_MUL;
            state_d     = ST_MUL;
            ready_d     = 1'b0;
          end else if ((op_s == OP_DIVU) && (i_datob != {SIZEDATA{1'b0}})) begin
            eng_start_s = 1'b1;
            eng_mode_s  = MD_DIV;
            state_d     = ST_DIV;
            ready_d     = 1'b0;
          end else if (op_s == OP_DIVU) begin
            lo_d       = {SIZEDATA{1'b1}};
            hi_d       = i_datoa;
            result_d   = {SIZEDATA{1'b1}};
            valid_d    = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            result_d  = alu_res_s;
            valid_d   = 1'b1;
            illegal_d = ~alu_known_s;
          end
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_MUL, ST_DIV: begin
        if (eng_done_s) begin
          hi_d     = eng_hi_s;
          lo_d     = eng_lo_s;
          result_d = eng_lo_s;
          valid_d  = 1'b1;
          state_d  = ST_IDLE;
          ready_d  = 1'b1;
        end else if (!eng_busy_s) begin
          // engine lost without completing: recover to IDLE rather than stall forever
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end else begin
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // Architectural and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b1;
      result_q   <= {SIZEDATA{1'b0}};
      valid_q    <= 1'b0;
      div_zero_q <= 1'b0;
      illegal_q  <= 1'b0;
      hi_q       <= {SIZEDATA{1'b0}};
      lo_q       <= {SIZEDATA{1'b0}};
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      div_zero_q <= div_zero_d;
      illegal_q  <= illegal_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
    end
  end

  alu_muldiv_iter #(.W(SIZEDATA)) u_iter (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_start (eng_start_s),
    .i_mode  (eng_mode_s),
    .i_a     (i_datoa),
    .i_b     (i_datob),
    .o_busy  (eng_busy_s),
    .o_done  (eng_done_s),
    .o_hi    (eng_hi_s),
    .o_lo    (eng_lo_s)
  );

  assign o_ready    = ready_q;
  assign o_result   = result_q;
  assign o_valid    = valid_q;
  assign o_div_zero = div_zero_q;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_alu_pipe_muldiv.sv
// Self-checking bench for alu_pipe_muldiv (SIZEDATA=8) against an arithmetic reference model.
module tb_alu_pipe_muldiv;

  localparam logic [5:0] SLL = 6'b000000, SRL = 6'b000010, SRA = 6'b000011;
  localparam logic [5:0] SLLV = 6'b000100, SRLV = 6'b000110, SRAV = 6'b000111;
  localparam logic [5:0] ADDU = 6'b100001, SUBU = 6'b100011, AND_ = 6'b100100;
  localparam logic [5:0] OR_ = 6'b100101, XOR_ = 6'b100110, NOR_ = 6'b100111, SLT = 6'b101010;
  localparam logic [5:0] ADDI = 6'b001000, SLTI = 6'b001010, ANDI = 6'b001100;
  localparam logic [5:0] ORI = 6'b001101, XORI = 6'b001110, LUI = 6'b001111;
  localparam logic [5:0] MFHI = 6'b010000, MFLO = 6'b010010, MULTU = 6'b011001, DIVU = 6'b011011;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       vld = 1'b0;
  logic       rdy;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic [5:0] op = 6'h00;
  logic [7:0] res;
  logic       ovld, dz, ill;

  int total = 0;
  int bad   = 0;
  logic [7:0] hi_m = 8'h00;
  logic [7:0] lo_m = 8'h00;

  logic [5:0] sc_ops [21] = '{SLL, SRL, SRA, SLLV, SRLV, SRAV, ADDU, SUBU, AND_, OR_, XOR_,
                              NOR_, SLT, ADDI, SLTI, ANDI, ORI, XORI, LUI, MFHI, MFLO};
  logic [29:0] tv [6] = '{{ADDU, 8'h7F, 8'h01, 8'h80}, {SUBU, 8'h00, 8'h01, 8'hFF},
                          {SRA, 8'h80, 8'h03, 8'hF0}, {SRL, 8'h80, 8'h03, 8'h10},
                          {SLT, 8'hF8, 8'h03, 8'h01}, {LUI, 8'h00, 8'h0A, 8'hA0}};

  alu_pipe_muldiv dut (
    .i_clock(clk), .i_reset(rst), .i_valid(vld), .o_ready(rdy),
    .i_datoa(a), .i_datob(b), .i_opcode(op),
    .o_result(res), .o_valid(ovld), .o_div_zero(dz), .o_illegal(ill)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1);
  end

  function automatic logic [7:0] ref_alu(input logic [5:0] o, input logic [7:0] x,
                                         input logic [7:0] y, output bit illegal);
    int ux, uy, sx, sy, sh, r;
    ux = x; uy = y;
    sx = (ux >= 128) ? ux - 256 : ux;
    sy = (uy >= 128) ? uy - 256 : uy;
    sh = uy % 8;
    illegal = 1'b0;
    r = 0;
    case (o)
      SLL, SLLV:   r = (ux * (1 << sh)) % 256;
      SRL, SRLV:   r = ux / (1 << sh);
      SRA, SRAV:   r = (sx >>> sh) & 255;
      ADDU, ADDI:  r = (ux + uy) % 256;
      SUBU:        r = (ux - uy + 256) % 256;
      AND_, ANDI:  r = ux & uy;
      OR_, ORI:    r = ux | uy;
      XOR_, XORI:  r = ux ^ uy;
      NOR_:        r = 255 - (ux | uy);
      SLT, SLTI:   r = (sx < sy) ? 1 : 0;
      LUI:         r = (uy * 16) % 256;
      MFHI:        r = hi_m;
      MFLO:        r = lo_m;
      default:     illegal = 1'b1;
    endcase
    return r[7:0];
  endfunction

  // Update the HI/LO model for a completed MULTU/DIVU; returns the expected o_result.
  function automatic logic [7:0] ref_long(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y);
    int p;
    if (o == MULTU) begin
      p = x * y;
      hi_m = 8'(p / 256);
      lo_m = 8'(p % 256);
    end else if (y == 8'h00) begin
      hi_m = x;
      lo_m = 8'hFF;
    end else begin
      hi_m = x % y;
      lo_m = x / y;
    end
    return lo_m;
  endfunction

  // Issue a long op and count cycles until o_valid; lat = -1 style bound at 40.
  task automatic run_long(input logic [5:0] o, input logic [7:0] x, input logic [7:0] y,
                          output int lat, output int rdy_hi);
    op = o; a = x; b = y; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    lat = 1; rdy_hi = 0;
    while (ovld !== 1'b1 && lat < 40) begin
      if (rdy !== 1'b0) rdy_hi++;
      @(negedge clk);
      lat++;
    end
  endtask

  // Back-to-back MFHI then MFLO; returns observed values and whether both pulsed valid.
  task automatic read_hilo(output logic [7:0] h, output logic [7:0] l, output bit both_valid);
    op = MFHI; vld = 1'b1;
    @(negedge clk);
    h = res; both_valid = (ovld === 1'b1);
    op = MFLO;
    @(negedge clk);
    l = res; both_valid = both_valid && (ovld === 1'b1);
    vld = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] h, l;
    bit v;
    rst = 1'b1; vld = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({res, ovld, dz, ill, rdy} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL reset_state got res=%h v=%b dz=%b ill=%b rdy=%b exp res=00 v=0 dz=0 ill=0 rdy=1",
               res, ovld, dz, ill, rdy);
    end
    hi_m = 8'h00; lo_m = 8'h00;
    read_hilo(h, l, v);
    total++;
    if ({h, l, v} !== {8'h00, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL reset_hilo got hi=%h lo=%h v=%b exp hi=00 lo=00 v=1", h, l, v);
    end
  endtask

  task automatic test_directed();
    for (int i = 0; i < 6; i++) begin
      op = tv[i][29:24]; a = tv[i][23:16]; b = tv[i][15:8]; vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      total++;
      if ({ovld, res, ill} !== {1'b1, tv[i][7:0], 1'b0}) begin
        bad++;
        $display("FAIL directed_%0d got v=%b res=%h ill=%b exp v=1 res=%h ill=0", i, ovld, res, ill, tv[i][7:0]);
      end
      @(negedge clk);
      total++;
      if (ovld !== 1'b0) begin
        bad++;
        $display("FAIL directed_pulse_%0d got v=%b exp v=0", i, ovld);
      end
    end
  endtask

  task automatic test_random_alu();
    logic [5:0] o;
    logic [7:0] x, y, e;
    bit il;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        o = 6'($urandom_range(0, 63));
        if (o == MULTU || o == DIVU) o = SUBU;
      end else begin
        o = sc_ops[$urandom_range(0, 20)];
      end
      x = 8'($urandom); y = 8'($urandom);
      e = ref_alu(o, x, y, il);
      op = o; a = x; b = y; vld = 1'b1;
      @(negedge clk);
      total++;
      if ({ovld, res, ill, dz} !== {1'b1, e, il, 1'b0}) begin
        bad++;
        $display("FAIL random_alu op=%b a=%h b=%h got v=%b res=%h ill=%b dz=%b exp v=1 res=%h ill=%b dz=0",
                 o, x, y, ovld, res, ill, dz, e, il);
      end
    end
    vld = 1'b0;
    @(negedge clk);
    total++;
    if (ovld !== 1'b0) begin
      bad++;
      $display("FAIL random_alu_idle got v=%b exp v=0", ovld);
    end
  endtask

  task automatic test_muldiv();
    int lat, rh, exp_lat;
    logic [5:0] o;
    logic [7:0] x, y, e, h, l;
    bit v, exp_dz;
    for (int i = 0; i < 15; i++) begin
      if (i == 0) begin o = MULTU; x = 8'd200; y = 8'd100; end
      else if (i == 1) begin o = DIVU; x = 8'd100; y = 8'd7; end
      else if (i == 2) begin o = DIVU; x = 8'd5; y = 8'd0; end
      else begin
        o = ($urandom_range(0, 1) == 0) ? MULTU : DIVU;
        x = 8'($urandom);
        y = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      end
      e = ref_long(o, x, y);
      exp_dz  = (o == DIVU) && (y == 8'h00);
      exp_lat = exp_dz ? 1 : 9;
      run_long(o, x, y, lat, rh);
      total++;
      if (lat != exp_lat || rh != 0 || {res, dz, rdy} !== {e, exp_dz, 1'b1}) begin
        bad++;
        $display("FAIL muldiv op=%b a=%h b=%h got lat=%0d rdy_early=%0d res=%h dz=%b rdy=%b exp lat=%0d rdy_early=0 res=%h dz=%b rdy=1",
                 o, x, y, lat, rh, res, dz, rdy, exp_lat, e, exp_dz);
      end
      read_hilo(h, l, v);
      total++;
      if ({h, l, v} !== {hi_m, lo_m, 1'b1}) begin
        bad++;
        $display("FAIL muldiv_hilo op=%b a=%h b=%h got hi=%h lo=%h v=%b exp hi=%h lo=%h v=1",
                 o, x, y, h, l, v, hi_m, lo_m);
      end
      if (i == 0) begin
        total++;
        if ({hi_m, lo_m} !== 16'h4E20 || {h, l} !== 16'h4E20) begin
          bad++;
          $display("FAIL multu_200x100 got hi=%h lo=%h exp hi=4e lo=20", h, l);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    int lat, pulses;
    logic [7:0] x, y, e;
    x = 8'($urandom); y = 8'($urandom);
    e = ref_long(MULTU, x, y);
    op = MULTU; a = x; b = y; vld = 1'b1;
    @(negedge clk);
    op = ADDU; a = 8'h03; b = 8'h04;
    lat = 1; pulses = 0;
    while (rdy !== 1'b1 && lat < 40) begin
      if (ovld === 1'b1) pulses++;
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat != 9 || pulses != 0 || {ovld, res} !== {1'b1, e}) begin
      bad++;
      $display("FAIL stall_mul got lat=%0d early_pulses=%0d v=%b res=%h exp lat=9 early_pulses=0 v=1 res=%h",
               lat, pulses, ovld, res, e);
    end
    @(negedge clk);
    vld = 1'b0;
    total++;
    if ({ovld, res} !== {1'b1, 8'h07}) begin
      bad++;
      $display("FAIL stall_addu got v=%b res=%h exp v=1 res=07", ovld, res);
    end
    @(negedge clk);
    total++;
    if (ovld !== 1'b0) begin
      bad++;
      $display("FAIL stall_extra got v=%b exp v=0", ovld);
    end
  endtask

  task automatic test_illegal();
    logic [7:0] h, l;
    bit v;
    op = 6'b111111; a = 8'($urandom); b = 8'($urandom); vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    total++;
    if ({ovld, ill, res, dz} !== {1'b1, 1'b1, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL illegal got v=%b ill=%b res=%h dz=%b exp v=1 ill=1 res=00 dz=0", ovld, ill, res, dz);
    end
    @(negedge clk);
    total++;
    if ({ovld, ill} !== 2'b00) begin
      bad++;
      $display("FAIL illegal_pulse got v=%b ill=%b exp v=0 ill=0", ovld, ill);
    end
    read_hilo(h, l, v);
    total++;
    if ({h, l, v} !== {hi_m, lo_m, 1'b1}) begin
      bad++;
      $display("FAIL illegal_hilo got hi=%h lo=%h v=%b exp hi=%h lo=%h v=1", h, l, v, hi_m, lo_m);
    end
  endtask

  task automatic test_reset_abort();
    int pulses;
    logic [7:0] h, l;
    bit v;
    op = DIVU; a = 8'd100; b = 8'd7; vld = 1'b1;
    @(negedge clk);
    vld = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hi_m = 8'h00; lo_m = 8'h00;
    total++;
    if ({rdy, ovld} !== 2'b10) begin
      bad++;
      $display("FAIL abort_state got rdy=%b v=%b exp rdy=1 v=0", rdy, ovld);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (ovld === 1'b1) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL abort_no_valid got pulses=%0d exp pulses=0", pulses);
    end
    read_hilo(h, l, v);
    total++;
    if ({h, l, v} !== {8'h00, 8'h00, 1'b1}) begin
      bad++;
      $display("FAIL abort_hilo got hi=%h lo=%h v=%b exp hi=00 lo=00 v=1", h, l, v);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_muldiv();
    test_back_to_back_stall();
    test_illegal();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
